// File: rtl/wb_unified_arbiter.sv
// Two-master (instruction fetch / data) to one-slave Wishbone arbiter with a per-transfer watchdog.
// Grant is registered; once granted, all routing and ack/err forwarding is combinational.
module wb_unified_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iwb_adr_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_we_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        timeout_o,
    output logic [1:0]  grant_o
);

    // State codes double as the grant_o encoding.
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_GNT_I = 2'b01;
    localparam logic [1:0] S_GNT_D = 2'b10;

    localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_last_d;
    logic [15:0] r_wcnt;
    logic        r_timeout;

    logic w_i_req;
    logic w_d_req;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_cyc;
    logic w_resp;
    logic w_expire;
    logic w_end;

    assign w_i_req = iwb_cyc_i & iwb_stb_i;
    assign w_d_req = dwb_cyc_i & dwb_stb_i;
    assign w_gnt_i = (r_state == S_GNT_I);
    assign w_gnt_d = (r_state == S_GNT_D);
    assign w_cyc   = (w_gnt_i & iwb_cyc_i) | (w_gnt_d & dwb_cyc_i);
    assign w_resp  = m_ack_i | m_err_i;

    // An ack or err arriving on the last allowed cycle beats the watchdog.
    assign w_expire = w_cyc & ~w_resp & (r_wcnt == WCNT_LAST);
    assign w_end    = ~w_cyc | w_resp | w_expire;

    always_comb begin
        m_adr_o = 32'h0;
        m_dat_o = 32'h0;
        m_we_o  = 1'b0;
        m_sel_o = 4'h0;
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        if (w_gnt_i) begin
            m_adr_o = iwb_adr_i;
            m_sel_o = 4'hF;
            m_cyc_o = iwb_cyc_i & ~w_expire;
            m_stb_o = iwb_cyc_i & iwb_stb_i & ~w_expire;
        end else if (w_gnt_d) begin
            m_adr_o = dwb_adr_i;
            m_dat_o = dwb_dat_i;
            m_we_o  = dwb_we_i;
            m_sel_o = dwb_sel_i;
            m_cyc_o = dwb_cyc_i & ~w_expire;
            m_stb_o = dwb_cyc_i & dwb_stb_i & ~w_expire;
        end
    end

    assign iwb_dat_o = m_dat_i;
    assign dwb_dat_o = m_dat_i;

    // Gating on the master's own cyc keeps an aborted transfer from seeing a late ack.
    assign iwb_ack_o = w_gnt_i & iwb_cyc_i & m_ack_i;
    assign iwb_err_o = w_gnt_i & ((iwb_cyc_i & m_err_i) | w_expire);
    assign dwb_ack_o = w_gnt_d & dwb_cyc_i & m_ack_i;
    assign dwb_err_o = w_gnt_d & ((dwb_cyc_i & m_err_i) | w_expire);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_d_req && (!w_i_req || !r_last_d)) begin
                    w_next_state = S_GNT_D;
                end else if (w_i_req) begin
                    w_next_state = S_GNT_I;
                end
            end
            S_GNT_I, S_GNT_D: begin
                if (w_end) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b0;
            r_wcnt    <= 16'h0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_next_state != S_IDLE) begin
                r_wcnt   <= 16'h0;
                r_last_d <= (w_next_state == S_GNT_D);
            end else if (r_state != S_IDLE && !w_end) begin
                r_wcnt <= r_wcnt + 16'h1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
    assign grant_o   = r_state;

endmodule

// File: tb/tb_wb_unified_arbiter.sv
// Directed bench for wb_unified_arbiter: expected master-side responses are queued at
// stimulus time and a negedge monitor pops and compares each one as the DUT presents it.
module tb_wb_unified_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iwb_adr_i, iwb_dat_o;
    logic        iwb_cyc_i, iwb_stb_i, iwb_ack_o, iwb_err_o;
    logic [31:0] dwb_adr_i, dwb_dat_i, dwb_dat_o;
    logic        dwb_we_i;
    logic [3:0]  dwb_sel_i;
    logic        dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i;
    logic [3:0]  m_sel_o;
    logic        timeout_o;
    logic [1:0]  grant_o;

    always #5 clk = ~clk;

    wb_unified_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
        .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
        .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
        .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .timeout_o(timeout_o), .grant_o(grant_o)
    );

    // Masters: request counters set by stimulus, completion counters advanced on ack/err.
    int i_req = 0, i_done = 0, i_cancel = 0;
    int d_req = 0, d_done = 0;
    assign iwb_cyc_i = (i_req > i_done + i_cancel);
    assign iwb_stb_i = iwb_cyc_i;
    assign dwb_cyc_i = (d_req > d_done);
    assign dwb_stb_i = dwb_cyc_i;

    logic ms_i, ms_d;
    initial forever begin
        @(negedge clk);
        ms_i = iwb_ack_o | iwb_err_o;
        ms_d = dwb_ack_o | dwb_err_o;
        @(posedge clk);
        #1;
        if (ms_i) i_done++;
        if (ms_d) d_done++;
    end

    // Slave: mode 0 acks, 1 errs, 2 never answers; answers slv_wait cycles into the grant.
    int          slv_mode = 0;
    int          slv_wait = 0;
    logic [31:0] scnt;
    assign m_ack_i = (grant_o != 2'b00) && (slv_mode == 0) && (scnt == 32'(slv_wait));
    assign m_err_i = (grant_o != 2'b00) && (slv_mode == 1) && (scnt == 32'(slv_wait));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) scnt <= 32'h0;
        else if (grant_o != 2'b00 && !m_ack_i && !m_err_i) scnt <= scnt + 32'h1;
        else scnt <= 32'h0;
    end

    typedef struct packed {
        logic [1:0]  who;
        logic        ack;
        logic        err;
        logic        stb;
        logic        tmo;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [31:0] gap;
        logic [31:0] at;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0, n_total = 0;
    int   cyc_n = 0;
    int   last_resp = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic push(input logic [1:0] who, input logic ack, input logic err,
                        input logic stb, input logic tmo, input logic [31:0] adr,
                        input logic we, input logic [3:0] sel, input logic [31:0] wdat,
                        input logic [31:0] rdat, input int gap, input int at);
        exp_t e;
        e = '{who, ack, err, stb, tmo, adr, we, sel, wdat, rdat, 32'(gap), 32'(at)};
        sbq.push_back(e);
    endtask

    // Monitor: one record per master-side ack/err, then an idle grant the following cycle.
    logic post_idle = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc_n++;
        if (post_idle) begin
            check("dead_cycle_grant", {30'h0, grant_o}, 32'h0);
            post_idle = 1'b0;
        end
        if (rst_n && (iwb_ack_o || iwb_err_o || dwb_ack_o || dwb_err_o)) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got i_ack=%b i_err=%b d_ack=%b d_err=%b expected none",
                         iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o);
            end else begin
                e = sbq.pop_front();
                check("grant", {30'h0, grant_o}, {30'h0, e.who});
                check("ack_err", {28'h0, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o},
                      (e.who == 2'b01) ? {28'h0, e.ack, e.err, 2'b00} : {28'h0, 2'b00, e.ack, e.err});
                check("m_adr", m_adr_o, e.adr);
                check("m_we_sel_stb", {26'h0, m_we_o, m_sel_o, m_stb_o}, {26'h0, e.we, e.sel, e.stb});
                check("m_dat_o", m_dat_o, e.wdat);
                check("rdata", (e.who == 2'b01) ? iwb_dat_o : dwb_dat_o, e.rdat);
                check("timeout_o", {31'h0, timeout_o}, {31'h0, e.tmo});
                if (e.gap != 0) check("resp_gap", 32'(cyc_n - last_resp), e.gap);
                if (e.at != 0) check("resp_cycle", 32'(cyc_n), e.at);
            end
            last_resp = cyc_n;
            post_idle = 1'b1;
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (k < 300 && !(i_done + i_cancel >= i_req && d_done >= d_req && grant_o == 2'b00)) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (k < 300) n_pass++;
        else $display("FAIL %s: busy after %0d cycles, expected idle", name, k);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        m_dat_i = 32'hCAFEF00D;
        iwb_adr_i = 32'h0; dwb_adr_i = 32'h0; dwb_dat_i = 32'h0;
        dwb_we_i = 1'b0; dwb_sel_i = 4'h0;

        // Reset with both masters requesting (D write, I fetch pending for release).
        iwb_adr_i = 32'h0000_0300;
        dwb_adr_i = 32'h0000_1000; dwb_dat_i = 32'h1; dwb_we_i = 1'b1; dwb_sel_i = 4'b0001;
        i_req = 1; d_req = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_cyc_stb", {30'h0, m_cyc_o, m_stb_o}, 32'h0);
        check("rst_m_adr", m_adr_o, 32'h0);
        check("rst_m_we_sel_dat", {27'h0, m_we_o, m_sel_o} | m_dat_o, 32'h0);
        check("rst_acks", {28'h0, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o}, 32'h0);
        check("rst_grant", {30'h0, grant_o}, 32'h0);
        check("rst_timeout", {31'h0, timeout_o}, 32'h0);
        check("rst_rdata_i", iwb_dat_o, 32'hCAFEF00D);
        check("rst_rdata_d", dwb_dat_o, 32'hCAFEF00D);

        // Simultaneous from reset: D wins first, I follows after one dead cycle.
        slv_mode = 0; slv_wait = 0;
        push(2'b10, 1, 0, 1, 0, 32'h1000, 1, 4'b0001, 32'h1, 32'hCAFEF00D, 0, 0);
        push(2'b01, 1, 0, 1, 0, 32'h300, 0, 4'hF, 32'h0, 32'hCAFEF00D, 2, 0);
        rst_n = 1'b1;
        wait_idle("simul_from_reset");

        // Single fetch, slave acks two cycles after strobe.
        iwb_adr_i = 32'h100; m_dat_i = 32'h0000_0013; slv_wait = 2;
        push(2'b01, 1, 0, 1, 0, 32'h100, 0, 4'hF, 32'h0, 32'h13, 0, cyc_n + 4);
        i_req++;
        wait_idle("single_fetch");

        // Fairness: both request continuously against a zero-wait slave.
        slv_wait = 0; m_dat_i = 32'h1234_5678;
        iwb_adr_i = 32'h200;
        dwb_adr_i = 32'h2000; dwb_dat_i = 32'hA5A5_0000; dwb_we_i = 1'b0; dwb_sel_i = 4'hF;
        for (int t = 0; t < 8; t++) begin
            if (t % 2 == 0) push(2'b10, 1, 0, 1, 0, 32'h2000, 0, 4'hF, 32'hA5A5_0000, 32'h1234_5678, (t == 0) ? 0 : 2, 0);
            else            push(2'b01, 1, 0, 1, 0, 32'h200, 0, 4'hF, 32'h0, 32'h1234_5678, 2, 0);
        end
        i_req += 4; d_req += 4;
        wait_idle("fairness");

        // Slave error on a D write: err forwarded same cycle, timeout untouched.
        slv_mode = 1; slv_wait = 1;
        dwb_adr_i = 32'h4000; dwb_dat_i = 32'h55; dwb_we_i = 1'b1; dwb_sel_i = 4'b1100;
        push(2'b10, 0, 1, 1, 0, 32'h4000, 1, 4'b1100, 32'h55, 32'h1234_5678, 0, cyc_n + 3);
        d_req++;
        wait_idle("slave_err");
        check("timeout_after_err", {31'h0, timeout_o}, 32'h0);

        // Ack on the last watchdog cycle beats expiry.
        slv_mode = 0; slv_wait = 7;
        dwb_adr_i = 32'h5000; dwb_we_i = 1'b0; dwb_sel_i = 4'hF; dwb_dat_i = 32'h0;
        push(2'b10, 1, 0, 1, 0, 32'h5000, 0, 4'hF, 32'h0, 32'h1234_5678, 0, cyc_n + 9);
        d_req++;
        wait_idle("ack_vs_expiry");
        check("timeout_after_late_ack", {31'h0, timeout_o}, 32'h0);

        // Watchdog: slave silent, err in the 8th grant cycle with strobe forced low.
        slv_mode = 2;
        dwb_adr_i = 32'h3000;
        push(2'b10, 0, 1, 0, 0, 32'h3000, 0, 4'hF, 32'h0, 32'h1234_5678, 0, cyc_n + 9);
        d_req++;
        wait_idle("watchdog");
        check("timeout_set", {31'h0, timeout_o}, 32'h1);

        // Successful transfer afterwards keeps the sticky flag.
        slv_mode = 0; slv_wait = 0; iwb_adr_i = 32'h500;
        push(2'b01, 1, 0, 1, 1, 32'h500, 0, 4'hF, 32'h0, 32'h1234_5678, 0, cyc_n + 2);
        i_req++;
        wait_idle("post_timeout_fetch");

        // Abort: I drops cyc in its 2nd grant cycle.
        slv_mode = 2; iwb_adr_i = 32'h400;
        i_req++;
        @(posedge clk);
        @(posedge clk);
        #1;
        i_cancel++;
        #1;
        check("abort_m_cyc_stb", {30'h0, m_cyc_o, m_stb_o}, 32'h0);
        check("abort_grant_held", {30'h0, grant_o}, 32'h1);
        check("abort_no_resp", {30'h0, iwb_ack_o, iwb_err_o}, 32'h0);
        @(posedge clk);
        #1;
        check("abort_idle_next", {30'h0, grant_o}, 32'h0);
        wait_idle("abort");
        check("timeout_still_set", {31'h0, timeout_o}, 32'h1);

        // Asynchronous reset mid-transfer.
        i_req++;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_m_cyc", {31'h0, m_cyc_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_m_cyc", {31'h0, m_cyc_o}, 32'h0);
        check("async_rst_grant", {30'h0, grant_o}, 32'h0);
        check("async_rst_timeout", {31'h0, timeout_o}, 32'h0);
        i_cancel++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle("after_async_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
